seq_shifter: RTL

SEQ_SHIFTER -- requirements
Module: seq_shifter

---
 rtl/seq_shifter.sv | 114 +++++++++++
 1 files changed

// File: rtl/seq_shifter.sv
// Multi-cycle SLL/SRL/SRA shifter: up to STEP bit positions per clock, start/ready, valid pulse.
// Define SEQ_SHIFTER_ROTATE_EN to turn op 2'b11 into ROTL; otherwise op 2'b11 behaves as SLL.
module seq_shifter #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    localparam int SAW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [SAW-1:0]   shamt_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o
);

    localparam logic [SAW-1:0]   STEP_W = SAW'(STEP);
    localparam logic [WIDTH-1:0] ONES   = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] opnd;
    logic [SAW-1:0]   rem;
    logic [1:0]       op_q;
    logic             sign_q;

    logic [SAW-1:0]   step_amt;
    logic [SAW-1:0]   rem_next;
    logic [WIDTH-1:0] shifted;

`ifdef SEQ_SHIFTER_ROTATE_EN
    logic [SAW:0]     rot_back;
`endif

    // Last SHIFT cycle may move fewer than STEP positions.
    always_comb begin
        step_amt = (rem < STEP_W) ? rem : STEP_W;
        rem_next = rem - step_amt;
    end

    always_comb begin
        shifted = opnd << step_amt;
`ifdef SEQ_SHIFTER_ROTATE_EN
        rot_back = (SAW+1)'(WIDTH) - (SAW+1)'(step_amt);
`endif
        case (op_q)
            2'b01: shifted = opnd >> step_amt;
            2'b10: shifted = (opnd >> step_amt) | (~(ONES >> step_amt) & {WIDTH{sign_q}});
`ifdef SEQ_SHIFTER_ROTATE_EN
            2'b11: shifted = (opnd << step_amt) | (opnd >> rot_back);
`endif
            default: shifted = opnd << step_amt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ready_o  <= 1'b1;
            valid_o  <= 1'b0;
            result_o <= '0;
            opnd     <= '0;
            rem      <= '0;
            op_q     <= '0;
            sign_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        opnd    <= data_i;
                        op_q    <= op_i;
                        rem     <= shamt_i;
                        sign_q  <= data_i[WIDTH-1];
                        ready_o <= 1'b0;
                        if (shamt_i == '0) begin
                            state    <= DONE;
                            valid_o  <= 1'b1;
                            result_o <= data_i;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    opnd <= shifted;
                    rem  <= rem_next;
                    if (rem_next == '0) begin
                        state    <= DONE;
                        valid_o  <= 1'b1;
                        result_o <= shifted;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    valid_o <= 1'b0;
                    ready_o <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    valid_o <= 1'b0;
                    ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule
